// File: rtl/maxpool_row_scheduler.sv
// Read-side sequencer for the maxpool line cache: tracks completed input rows and
// issues one paced FIFO read burst per output window row, with sync/reuse markers.
module maxpool_row_scheduler #(
  parameter int SIZE    = 14,
  parameter int CHANNEL = 256,
  parameter int ROWS    = 3,
  parameter int STRIDE  = 2,
  parameter int PAD     = 1,
  parameter int GAP     = 0,
  parameter int PADWAIT = 21,
  localparam int OSIZE  = (SIZE + 2*PAD - ROWS) / STRIDE + 1,
  localparam int ROW_W  = $clog2(OSIZE + 1)
) (
  input  logic             i_sclk,
  input  logic             i_rst,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_valid,
  output logic             o_rdreq,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_valid,
  output logic             o_reuse,
  output logic [ROW_W-1:0] o_row,
  output logic             o_done,
  output logic             o_err
);
  localparam int RBEATS = SIZE * CHANNEL;
  localparam int BEAT_W = $clog2(RBEATS + 1);
  localparam int RIN_W  = $clog2(SIZE + 1);
  localparam int RD_W   = (RBEATS > 1) ? $clog2(RBEATS) : 1;
  localparam int CH_W   = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int PW_W   = (PADWAIT > 1) ? $clog2(PADWAIT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PADW, S_HS, S_READ, S_GAPW} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [RIN_W-1:0]    rows_in_q, rows_in_d;
  logic                armed_q, armed_d;
  logic                err_q, err_d;
  logic [ROW_W-1:0]    r_q, r_d;
  logic [PW_W-1:0]     pw_q, pw_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                done_q, done_d;
  logic                vsync_q, valid_q, reuse_q, reuse_d;
  logic                row_done, last_beat, rdreq;
  int                  need_rows;

  assign row_done  = (beat_cnt_q == BEAT_W'(RBEATS));
  assign last_beat = i_valid && (beat_cnt_q == BEAT_W'(RBEATS - 1));
  assign rdreq     = (state_q == S_READ);

  always_comb begin
    need_rows = STRIDE * int'(r_q) + ROWS - PAD;
    if (need_rows > SIZE) need_rows = SIZE;
  end

  always_comb begin
    // NOTE: every _d starts from its current value so no path leaves it unassigned (no latches).
    beat_cnt_d = beat_cnt_q;
    rows_in_d  = rows_in_q;
    armed_d    = armed_q;
    err_d      = err_q;
    state_d    = state_q;
    r_d        = r_q;
    pw_d       = pw_q;
    rd_d       = rd_q;
    ch_d       = ch_q;
    gap_d      = gap_q;
    done_d     = 1'b0;

    if (row_done) begin
      beat_cnt_d = '0;
      if (int'(rows_in_q) != SIZE) rows_in_d = rows_in_q + 1'b1;
    end
    // An hsync landing on the final beat of a row is part of that row, not a restart.
    if (i_hsync && !last_beat) begin
      beat_cnt_d = '0;
      armed_d    = 1'b1;
      if (beat_cnt_q != '0 && !row_done) err_d = 1'b1;
    end
    if (i_valid) begin
      if (last_beat) begin
        beat_cnt_d = BEAT_W'(RBEATS);
        armed_d    = 1'b0;
      end else begin
        beat_cnt_d = beat_cnt_d + 1'b1;
      end
      if (int'(rows_in_q) == SIZE) err_d = 1'b1;
      if (!armed_q && !i_hsync)    err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: if (vsync_q) state_d = S_WAIT;
      S_WAIT: begin
        if (int'(rows_in_q) >= need_rows) begin
          pw_d    = '0;
          state_d = (PADWAIT == 0) ? S_HS : S_PADW;
        end
      end
      S_PADW: begin
        if (pw_q == PW_W'(PADWAIT - 1)) state_d = S_HS;
        else                            pw_d    = pw_q + 1'b1;
      end
      S_HS: begin
        rd_d    = '0;
        ch_d    = '0;
        state_d = S_READ;
      end
      S_READ: begin
        rd_d = rd_q + 1'b1;
        if (rd_q == RD_W'(RBEATS - 1)) begin
          r_d = r_q + 1'b1;
          if (int'(r_q) == OSIZE - 1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (ch_q == CH_W'(CHANNEL - 1)) begin
          ch_d = '0;
          if (GAP > 0) begin
            gap_d   = '0;
            state_d = S_GAPW;
          end
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      S_GAPW: begin
        if (gap_q == GAP_W'(GAP - 1)) state_d = S_READ;
        else                          gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Frame start overrides everything, including a burst in flight.
    if (i_vsync) begin
      beat_cnt_d = '0;
      rows_in_d  = '0;
      armed_d    = 1'b0;
      err_d      = 1'b0;
      state_d    = S_IDLE;
      r_d        = '0;
      pw_d       = '0;
      rd_d       = '0;
      ch_d       = '0;
      gap_d      = '0;
      done_d     = 1'b0;
    end
  end

  assign reuse_d = rdreq && (int'(r_q) < OSIZE - 1);

  // NOTE: state registers take non-blocking assignments only; all next-state math is in always_comb.
  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      rows_in_q  <= '0;
      armed_q    <= 1'b0;
      err_q      <= 1'b0;
      r_q        <= '0;
      pw_q       <= '0;
      rd_q       <= '0;
      ch_q       <= '0;
      gap_q      <= '0;
      done_q     <= 1'b0;
      vsync_q    <= 1'b0;
      valid_q    <= 1'b0;
      reuse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rows_in_q  <= rows_in_d;
      armed_q    <= armed_d;
      err_q      <= err_d;
      r_q        <= r_d;
      pw_q       <= pw_d;
      rd_q       <= rd_d;
      ch_q       <= ch_d;
      gap_q      <= gap_d;
      done_q     <= done_d;
      vsync_q    <= i_vsync;
      valid_q    <= rdreq;
      reuse_q    <= reuse_d;
    end
  end

  // Read enable decodes straight from state so a reset drops it without waiting for a clock.
  assign o_rdreq = rdreq;
  assign o_hsync = (state_q == S_HS);
  assign o_vsync = vsync_q;
  assign o_valid = valid_q;
  assign o_reuse = reuse_q;
  assign o_row   = r_q;
  assign o_done  = done_q;
  assign o_err   = err_q;
endmodule

// File: tb/tb_maxpool_row_scheduler.sv
// Directed bench: instance A (GAP=1, PADWAIT=3) and instance B (GAP=0, PADWAIT=0)
// share one input stream; SIZE=4, CHANNEL=2 so OSIZE=2, RBEATS=8, need = 2 then 4.
module tb_maxpool_row_scheduler;
  logic clk = 1'b0;
  logic rst, vsync, hsync, valid;
  logic a_rdreq, a_vsync, a_hsync, a_valid, a_reuse, a_done, a_err;
  logic b_rdreq, b_vsync, b_hsync, b_valid, b_reuse, b_done, b_err;
  logic [1:0] a_row, b_row;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  int a_nb = 0, a_vcnt = 0, a_ndone = 0, a_done_cyc = 0, a_done_v = 0;
  int a_hs [64], a_first [64], a_last [64], a_rd [64], a_ru [64], a_frow [64];
  int b_nb = 0, b_ndone = 0;
  int b_hs [64], b_first [64], b_last [64], b_rd [64];

  maxpool_row_scheduler #(
    .SIZE(4), .CHANNEL(2), .ROWS(3), .STRIDE(2), .PAD(1), .GAP(1), .PADWAIT(3)
  ) dut_a (
    .i_sclk(clk), .i_rst(rst), .i_vsync(vsync), .i_hsync(hsync), .i_valid(valid),
    .o_rdreq(a_rdreq), .o_vsync(a_vsync), .o_hsync(a_hsync), .o_valid(a_valid),
    .o_reuse(a_reuse), .o_row(a_row), .o_done(a_done), .o_err(a_err)
  );

  maxpool_row_scheduler #(
    .SIZE(4), .CHANNEL(2), .ROWS(3), .STRIDE(2), .PAD(1), .GAP(0), .PADWAIT(0)
  ) dut_b (
    .i_sclk(clk), .i_rst(rst), .i_vsync(vsync), .i_hsync(hsync), .i_valid(valid),
    .o_rdreq(b_rdreq), .o_vsync(b_vsync), .o_hsync(b_hsync), .o_valid(b_valid),
    .o_reuse(b_reuse), .o_row(b_row), .o_done(b_done), .o_err(b_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Burst log, sampled on the falling edge; a new burst index opens on each o_hsync.
  always @(negedge clk) begin
    if (a_hsync) begin
      a_hs[a_nb & 63] <= cyc;
      a_rd[a_nb & 63] <= 0;
      a_ru[a_nb & 63] <= 0;
      a_nb            <= a_nb + 1;
    end
    if (a_rdreq) begin
      if (a_rd[(a_nb - 1) & 63] == 0) begin
        a_first[(a_nb - 1) & 63] <= cyc;
        a_frow[(a_nb - 1) & 63]  <= int'(a_row);
      end
      a_rd[(a_nb - 1) & 63]   <= a_rd[(a_nb - 1) & 63] + 1;
      a_last[(a_nb - 1) & 63] <= cyc;
    end
    if (a_valid) begin
      a_vcnt <= a_vcnt + 1;
      if (a_reuse) a_ru[(a_nb - 1) & 63] <= a_ru[(a_nb - 1) & 63] + 1;
    end
    if (a_done) begin
      a_done_cyc <= cyc;
      a_done_v   <= a_vcnt + (a_valid ? 1 : 0);
      a_ndone    <= a_ndone + 1;
    end
  end

  always @(negedge clk) begin
    if (b_hsync) begin
      b_hs[b_nb & 63] <= cyc;
      b_rd[b_nb & 63] <= 0;
      b_nb            <= b_nb + 1;
    end
    if (b_rdreq) begin
      if (b_rd[(b_nb - 1) & 63] == 0) b_first[(b_nb - 1) & 63] <= cyc;
      b_rd[(b_nb - 1) & 63]   <= b_rd[(b_nb - 1) & 63] + 1;
      b_last[(b_nb - 1) & 63] <= cyc;
    end
    if (b_done) b_ndone <= b_ndone + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends n beats, idle cycles after each; last = edge that sampled the final beat.
  task automatic send_beats(input int n, input int idle, input bit with_hs, output int last);
    last = 0;
    for (int i = 0; i < n; i++) begin
      hsync = with_hs && (i == 0);
      valid = 1'b1;
      tick();
      last  = cyc;
      hsync = 1'b0;
      valid = 1'b0;
      repeat (idle) tick();
    end
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("vsync_rise", 32'(a_vsync), 1);
    tick();
    check("vsync_fall", 32'(a_vsync), 0);
  endtask

  // Full 4-row frame; row k ends at edge l[k], rows_in updates one edge later.
  task automatic run_frame(input int idle);
    int l [4];
    int ba, bb, bv, bd, bbd;
    frame_start();
    ba = a_nb; bb = b_nb; bv = a_vcnt; bd = a_ndone; bbd = b_ndone;
    for (int r = 0; r < 4; r++) begin
      send_beats(8, idle, 1'b1, l[r]);
      if (r == 1) check("hs_before_need", a_nb, ba);
    end
    repeat (30) tick();
    check("a_hs0",    a_hs[ba & 63],          l[1] + 5);
    check("a_first0", a_first[ba & 63],       l[1] + 6);
    check("a_last0",  a_last[ba & 63],        l[1] + 16);
    check("a_cnt0",   a_rd[ba & 63],          8);
    check("a_row0",   a_frow[ba & 63],        0);
    check("a_reuse0", a_ru[ba & 63],          8);
    check("a_first1", a_first[(ba + 1) & 63], l[3] + 6);
    check("a_last1",  a_last[(ba + 1) & 63],  l[3] + 16);
    check("a_cnt1",   a_rd[(ba + 1) & 63],    8);
    check("a_row1",   a_frow[(ba + 1) & 63],  1);
    check("a_reuse1", a_ru[(ba + 1) & 63],    0);
    check("a_bursts", a_nb - ba,              2);
    check("a_done_cyc", a_done_cyc,           l[3] + 17);
    check("a_done_valids", a_done_v - bv,     16);
    check("a_done_cnt", a_ndone - bd,         1);
    check("a_err_frame", 32'(a_err),          0);
    check("b_hs0",    b_hs[bb & 63],          l[1] + 2);
    check("b_first0", b_first[bb & 63],       l[1] + 3);
    check("b_last0",  b_last[bb & 63],        l[1] + 10);
    check("b_cnt0",   b_rd[bb & 63],          8);
    check("b_hs1",    b_hs[(bb + 1) & 63],    l[3] + 2);
    check("b_last1",  b_last[(bb + 1) & 63],  l[3] + 10);
    check("b_done_cnt", b_ndone - bbd,        1);
    check("b_err_frame", 32'(b_err),          0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1, snap_a, snap_b;
    rst = 1'b1; vsync = 1'b0; hsync = 1'b0; valid = 1'b0;
    repeat (3) tick();
    check("reset_outs_a", 32'({a_rdreq, a_vsync, a_hsync, a_valid, a_reuse, a_row, a_done, a_err}), 0);
    check("reset_outs_b", 32'({b_rdreq, b_vsync, b_hsync, b_valid, b_reuse, b_row, b_done, b_err}), 0);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_no_rdreq", 32'(a_rdreq), 0);

    run_frame(0);
    run_frame(3);

    // Frame restart in the middle of burst 0 (fourth read beat), then a clean replay.
    frame_start();
    send_beats(8, 0, 1'b1, l0);
    send_beats(8, 0, 1'b1, l1);
    while (cyc < l1 + 10) tick();
    check("abort_pre_rdreq", 32'(a_rdreq), 1);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("abort_rdreq", 32'(a_rdreq), 0);
    check("abort_row",   32'(a_row),   0);
    check("abort_vsync", 32'(a_vsync), 1);
    tick();
    check("abort_rdreq_hold", 32'(a_rdreq), 0);
    run_frame(0);

    // Short row: hsync after 5 beats.
    frame_start();
    send_beats(5, 0, 1'b1, l0);
    check("err_before_short", 32'(a_err), 0);
    send_beats(8, 0, 1'b1, l0);
    check("err_short_row", 32'(a_err), 1);
    repeat (5) tick();
    check("err_sticky", 32'(a_err), 1);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("err_clr_vsync", 32'(a_err), 0);

    // Row data without a leading hsync.
    frame_start();
    send_beats(8, 0, 1'b1, l0);
    check("err_after_good_row", 32'(a_err), 0);
    send_beats(2, 0, 1'b0, l0);
    check("err_no_hsync", 32'(a_err), 1);

    // A fifth row of data.
    frame_start();
    for (int r = 0; r < 4; r++) send_beats(8, 0, 1'b1, l0);
    check("err_four_rows", 32'(a_err), 0);
    send_beats(8, 0, 1'b1, l0);
    check("err_fifth_row", 32'(a_err), 1);
    repeat (30) tick();

    // Asynchronous reset mid-READ, then rows without vsync must not start a burst.
    frame_start();
    send_beats(8, 0, 1'b1, l0);
    send_beats(8, 0, 1'b1, l1);
    while (cyc < l1 + 7) tick();
    check("rst_pre_rdreq", 32'(a_rdreq), 1);
    #3 rst = 1'b1;
    #1;
    check("rst_async_a", 32'({a_rdreq, a_vsync, a_hsync, a_valid, a_reuse, a_row, a_done, a_err}), 0);
    check("rst_async_b", 32'({b_rdreq, b_vsync, b_hsync, b_valid, b_reuse, b_row, b_done, b_err}), 0);
    #2 rst = 1'b0;
    tick();
    snap_a = a_nb;
    snap_b = b_nb;
    for (int r = 0; r < 4; r++) send_beats(8, 0, 1'b1, l0);
    repeat (20) tick();
    check("rst_idle_a", a_nb, snap_a);
    check("rst_idle_b", b_nb, snap_b);
    check("rst_idle_rdreq", 32'(a_rdreq), 0);
    run_frame(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
